// File: rtl/dmem_req_queue.sv
// dmem_req_queue
// Data-memory front end between the core's M/W stages and the data cache.
// Loads and stores go into a program-ordered request FIFO, and the cache
// only ever sees the FIFO head. Outstanding loads are tracked by a bounded
// counter, so the core stalls only when the FIFO is full or too many loads
// are waiting for data.
//
// Build option: define DMEM_RSP_CHK_EN to build a sticky response-protocol
// error flag on rsp_err. Without the macro, rsp_err is tied to 0 and no
// check logic is built.
module dmem_req_queue #(
    parameter int ADDR_W      = 21,
    parameter int REQ_DEPTH   = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             Lw,
    input  logic                             MemWrite,
    input  logic [3:0]                       ByteEn,
    input  logic [31:0]                      DataAdr,
    input  logic [31:0]                      WriteData,
    output logic [31:0]                      read_data,
    output logic                             wb_valid,
    output logic                             stall_m,
    output logic                             stall_w,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
    output logic [ADDR_W-1:0]                cache_req_addr,
    output logic [31:0]                      cache_req_data,
    output logic [3:0]                       cache_req_be,
    output logic                             cache_req_wr,
    output logic                             cache_req_valid,
    input  logic                             cache_req_ready,
    input  logic [31:0]                      cache_rsp_data,
    input  logic                             cache_rsp_valid,
    output logic                             rsp_err
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    // FIFO storage, one field array per request component
    logic [ADDR_W-1:0]    addr_mem [REQ_DEPTH];
    logic [31:0]          data_mem [REQ_DEPTH];
    logic [3:0]           be_mem   [REQ_DEPTH];
    logic [REQ_DEPTH-1:0] read_mem;

    // Pointers carry one extra wrap bit so that full and empty can be told apart
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    logic full;
    logic empty;
    logic active;
    logic is_load;
    logic at_cap;
    logic push;
    logic pop;
    logic load_push;

    logic [ADDR_W-1:0] push_addr;
    logic [3:0]        push_be;

    // The byte-offset bits and the bits above the word address never reach
    // the cache; the reduction keeps the whole address bus visibly consumed.
    logic unused_adr;
    assign unused_adr = ^DataAdr;

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];

    // Full when the indices match but the wrap bits differ; empty when the
    // pointers are identical
    assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign empty = (wr_ptr == rd_ptr);

    // A store takes precedence when both request strobes are raised
    assign active  = Lw | MemWrite;
    assign is_load = Lw & ~MemWrite;
    assign at_cap  = (pending_cnt == CNT_MAX);

    // Full is taken from the current state, so a same-cycle pop never frees
    // a slot for a push
    assign stall_m   = active & (full | (is_load & at_cap));
    assign push      = active & ~stall_m;
    assign pop       = ~empty & cache_req_ready;
    assign load_push = push & is_load;

    // Loads always request the full word
    assign push_addr = DataAdr[ADDR_W+1:2];
    assign push_be   = is_load ? 4'hF : ByteEn;

    // Responses pass straight through to the write-back stage
    assign read_data = cache_rsp_data;
    assign wb_valid  = cache_rsp_valid;
    assign stall_w   = (pending_cnt != '0) & ~cache_rsp_valid;

    assign cache_req_valid = ~empty;

    // Capture the accepted request into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= WriteData;
            be_mem[wr_idx]   <= push_be;
            read_mem[wr_idx] <= is_load;
        end
    end

    // Advance the write and read pointers on push and pop; reset flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Count accepted loads still waiting for data; a response with nothing
    // outstanding leaves the counter at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_cnt <= '0;
        end else if (load_push && !cache_rsp_valid) begin
            pending_cnt <= pending_cnt + CNT_ONE;
        end else if (!load_push && cache_rsp_valid && (pending_cnt != '0)) begin
            pending_cnt <= pending_cnt - CNT_ONE;
        end
    end

    // Present the FIFO head to the cache, forcing zeros while empty
    always_comb begin
        cache_req_addr = '0;
        cache_req_data = '0;
        cache_req_be   = '0;
        cache_req_wr   = 1'b0;
        if (!empty) begin
            cache_req_addr = addr_mem[rd_idx];
            cache_req_data = data_mem[rd_idx];
            cache_req_be   = be_mem[rd_idx];
            cache_req_wr   = read_mem[rd_idx];
        end
    end

`ifdef DMEM_RSP_CHK_EN
    logic err_q;

    // Sticky flag: a response with no load outstanding, or a load accepted
    // at the pending cap with no response to offset it; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((cache_rsp_valid && (pending_cnt == '0)) ||
                     (load_push && at_cap && !cache_rsp_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_req_queue.sv
// Self-checking bench for dmem_req_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_dmem_req_queue;

    localparam int ADDR_W      = 21;
    localparam int REQ_DEPTH   = 4;
    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = $clog2(MAX_PENDING + 1);

    logic              clk;
    logic              reset;
    logic              lw;
    logic              mem_write;
    logic [3:0]        byte_en;
    logic [31:0]       data_adr;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              wb_valid;
    logic              stall_m;
    logic              stall_w;
    logic [CNT_W-1:0]  pending_cnt;
    logic [ADDR_W-1:0] cache_req_addr;
    logic [31:0]       cache_req_data;
    logic [3:0]        cache_req_be;
    logic              cache_req_wr;
    logic              cache_req_valid;
    logic              cache_req_ready;
    logic [31:0]       cache_rsp_data;
    logic              cache_rsp_valid;
    logic              rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
        logic              wr;
    } entry_t;

    entry_t mq[$];
    int     mpend;

    dmem_req_queue #(
        .ADDR_W(ADDR_W),
        .REQ_DEPTH(REQ_DEPTH),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Lw(lw),
        .MemWrite(mem_write),
        .ByteEn(byte_en),
        .DataAdr(data_adr),
        .WriteData(write_data),
        .read_data(read_data),
        .wb_valid(wb_valid),
        .stall_m(stall_m),
        .stall_w(stall_w),
        .pending_cnt(pending_cnt),
        .cache_req_addr(cache_req_addr),
        .cache_req_data(cache_req_data),
        .cache_req_be(cache_req_be),
        .cache_req_wr(cache_req_wr),
        .cache_req_valid(cache_req_valid),
        .cache_req_ready(cache_req_ready),
        .cache_rsp_data(cache_rsp_data),
        .cache_rsp_valid(cache_rsp_valid),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: advance one clock using the inputs currently driven
    task automatic model_step();
        bit     act;
        bit     ld;
        bit     acc;
        entry_t e;
        act = lw || mem_write;
        ld  = lw && !mem_write;
        acc = act && !((mq.size() == REQ_DEPTH) || (ld && mpend == MAX_PENDING));
        if (mq.size() != 0 && cache_req_ready) e = mq.pop_front();
        if (acc) begin
            e.addr = ADDR_W'(data_adr / 4);
            e.data = write_data;
            e.be   = ld ? 4'hF : byte_en;
            e.wr   = ld;
            mq.push_back(e);
            if (ld) mpend = mpend + 1;
        end
        if (cache_rsp_valid && mpend > 0) mpend = mpend - 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lw              = 1'b0;
        mem_write       = 1'b0;
        byte_en         = 4'h0;
        data_adr        = 32'h0;
        write_data      = 32'h0;
        cache_req_ready = 1'b0;
        cache_rsp_data  = 32'h0;
        cache_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mpend = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", cache_req_valid); end
        n_cmp++; if (pending_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_pending: got %0d expected 0", pending_cnt); end
        n_cmp++; if (stall_m !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall_m: got %b expected 0", stall_m); end
        n_cmp++; if (stall_w !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall_w: got %b expected 0", stall_w); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if (cache_req_addr !== '0 || cache_req_be !== 4'h0 || cache_req_wr !== 1'b0 || cache_req_data !== 32'h0)
            begin n_fail++; $display("[TB] FAIL reset_head_zero: got addr %0h be %0h wr %b data %0h expected all 0", cache_req_addr, cache_req_be, cache_req_wr, cache_req_data); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mpend = 0;
    endtask

    task automatic test_queue_fill();
        logic [ADDR_W-1:0] sa [5];
        logic [31:0]       sd [5];
        logic [3:0]        sb [5];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem_write  = 1'b1;
            byte_en    = 4'($urandom);
            data_adr   = $urandom;
            write_data = $urandom;
            sa[k] = ADDR_W'(data_adr / 4);
            sd[k] = write_data;
            sb[k] = byte_en;
            #1;
            n_cmp++;
            if (stall_m !== (k == 4)) begin n_fail++; $display("[TB] FAIL fill_stall_m[%0d]: got %b expected %b", k, stall_m, (k == 4)); end
            tick();
        end
        // Store 5 still held; ready rises while the FIFO is full
        cache_req_ready = 1'b1;
        #1;
        n_cmp++; if (stall_m !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_stall_on_pop: got %b expected 1", stall_m); end
        n_cmp++; if (cache_req_addr !== sa[0] || cache_req_data !== sd[0] || cache_req_be !== sb[0] || cache_req_wr !== 1'b0)
            begin n_fail++; $display("[TB] FAIL fill_head0: got addr %0h data %0h be %0h expected addr %0h data %0h be %0h", cache_req_addr, cache_req_data, cache_req_be, sa[0], sd[0], sb[0]); end
        tick();
        #1;
        n_cmp++; if (stall_m !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_store5_accept: got stall_m %b expected 0", stall_m); end
        n_cmp++; if (cache_req_addr !== sa[1] || cache_req_data !== sd[1]) begin n_fail++; $display("[TB] FAIL fill_head1: got addr %0h data %0h expected addr %0h data %0h", cache_req_addr, cache_req_data, sa[1], sd[1]); end
        tick();
        mem_write = 1'b0;
        for (int k = 2; k < 5; k++) begin
            #1;
            n_cmp++;
            if (cache_req_valid !== 1'b1 || cache_req_addr !== sa[k] || cache_req_data !== sd[k] || cache_req_be !== sb[k])
                begin n_fail++; $display("[TB] FAIL fill_head%0d: got v %b addr %0h data %0h be %0h expected v 1 addr %0h data %0h be %0h", k, cache_req_valid, cache_req_addr, cache_req_data, cache_req_be, sa[k], sd[k], sb[k]); end
            tick();
        end
        #1;
        n_cmp++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_drained: got valid %b expected 0", cache_req_valid); end
    endtask

    task automatic test_byte_store();
        do_reset();
        mem_write  = 1'b1;
        byte_en    = 4'b0011;
        data_adr   = 32'h0000_0104;
        write_data = 32'hCAFE_1234;
        tick();
        mem_write = 1'b0;
        #1;
        n_cmp++; if (cache_req_addr !== 21'h41) begin n_fail++; $display("[TB] FAIL byte_addr: got %0h expected 41", cache_req_addr); end
        n_cmp++; if (cache_req_be !== 4'b0011) begin n_fail++; $display("[TB] FAIL byte_be: got %b expected 0011", cache_req_be); end
        n_cmp++; if (cache_req_wr !== 1'b0 || cache_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL byte_wr_valid: got wr %b valid %b expected wr 0 valid 1", cache_req_wr, cache_req_valid); end
        n_cmp++; if (cache_req_data !== 32'hCAFE_1234) begin n_fail++; $display("[TB] FAIL byte_data: got %0h expected cafe1234", cache_req_data); end
        cache_req_ready = 1'b1;
        tick();
    endtask

    task automatic test_pending_cap();
        do_reset();
        cache_req_ready = 1'b1;
        lw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_adr = $urandom;
            #1;
            n_cmp++; if (stall_m !== 1'b0 || pending_cnt !== CNT_W'(k)) begin n_fail++; $display("[TB] FAIL cap_load%0d: got stall_m %b pending %0d expected 0 and %0d", k, stall_m, pending_cnt, k); end
            tick();
        end
        #1;
        n_cmp++; if (pending_cnt !== 3'd4) begin n_fail++; $display("[TB] FAIL cap_count: got %0d expected 4", pending_cnt); end
        n_cmp++; if (stall_m !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_stall_m: got %b expected 1", stall_m); end
        n_cmp++; if (stall_w !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_stall_w: got %b expected 1", stall_w); end
        tick();
        cache_rsp_valid = 1'b1;
        cache_rsp_data  = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (read_data !== 32'hDEAD_BEEF || wb_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_rsp: got data %0h wb_valid %b expected deadbeef 1", read_data, wb_valid); end
        n_cmp++; if (stall_m !== 1'b1 || stall_w !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_rsp_stalls: got stall_m %b stall_w %b expected 1 0", stall_m, stall_w); end
        tick();
        cache_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (stall_m !== 1'b0 || pending_cnt !== 3'd3) begin n_fail++; $display("[TB] FAIL cap_load5_accept: got stall_m %b pending %0d expected 0 and 3", stall_m, pending_cnt); end
        tick();
        lw = 1'b0;
        #1;
        n_cmp++; if (pending_cnt !== 3'd4) begin n_fail++; $display("[TB] FAIL cap_after_load5: got %0d expected 4", pending_cnt); end
        cache_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        cache_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (pending_cnt !== '0 || cache_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_drain: got pending %0d valid %b expected 0 0", pending_cnt, cache_req_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cache_req_ready = 1'b1;
        lw = 1'b1;
        tick();
        tick();
        cache_rsp_valid = 1'b1;
        cache_rsp_data  = $urandom;
        #1;
        n_cmp++; if (pending_cnt !== 3'd2 || stall_m !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_pre: got pending %0d stall_m %b expected 2 0", pending_cnt, stall_m); end
        n_cmp++; if (stall_w !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_stall_w: got %b expected 0", stall_w); end
        tick();
        lw = 1'b0;
        cache_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (pending_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL simul_count: got %0d expected 2", pending_cnt); end
        cache_rsp_valid = 1'b1;
        tick();
        tick();
        cache_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        lw = 1'b1;
        data_adr = $urandom;
        tick();
        data_adr = $urandom;
        tick();
        lw = 1'b0;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        #1;
        n_cmp++; if (cache_req_valid !== 1'b1 || pending_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL mid_pre: got valid %b pending %0d expected 1 2", cache_req_valid, pending_cnt); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid: got %b expected 0", cache_req_valid); end
        n_cmp++; if (pending_cnt !== '0 || stall_w !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_pending: got %0d stall_w %b expected 0 0", pending_cnt, stall_w); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mpend = 0;
    endtask

    task automatic test_error_flag();
        logic exp_err;
`ifdef DMEM_RSP_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        cache_rsp_valid = 1'b1;
        #1;
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_before: got %b expected 0", rsp_err); end
        tick();
        cache_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (rsp_err !== exp_err || pending_cnt !== '0) begin n_fail++; $display("[TB] FAIL err_hold%0d: got rsp_err %b pending %0d expected %b 0", k, rsp_err, pending_cnt, exp_err); end
            tick();
        end
        do_reset();
        #1;
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cleared: got %b expected 0", rsp_err); end
    endtask

    task automatic test_random();
        int                r;
        logic              e_valid;
        logic [ADDR_W-1:0] e_addr;
        logic [3:0]        e_be;
        logic              e_wr;
        logic              e_full;
        logic              e_stall_m;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r          = int'($urandom_range(0, 7));
            lw         = (r >= 3 && r <= 5) || r == 7;
            mem_write  = (r >= 6);
            byte_en    = 4'($urandom);
            data_adr   = $urandom;
            write_data = $urandom;
            cache_req_ready = ($urandom_range(0, 99) < 55);
            cache_rsp_valid = (mpend > 0) && ($urandom_range(0, 99) < 35);
            cache_rsp_data  = $urandom;
            #1;
            e_valid = (mq.size() != 0);
            e_addr  = e_valid ? mq[0].addr : '0;
            e_be    = e_valid ? mq[0].be : 4'h0;
            e_wr    = e_valid ? mq[0].wr : 1'b0;
            e_full  = (mq.size() == REQ_DEPTH);
            e_stall_m = (lw || mem_write) && (e_full || (lw && !mem_write && mpend == MAX_PENDING));
            n_cmp++; if (stall_m !== e_stall_m) begin n_fail++; $display("[TB] FAIL rnd_stall_m@%0d: got %b expected %b", c, stall_m, e_stall_m); end
            n_cmp++; if (stall_w !== ((mpend != 0) && !cache_rsp_valid)) begin n_fail++; $display("[TB] FAIL rnd_stall_w@%0d: got %b expected %b", c, stall_w, (mpend != 0) && !cache_rsp_valid); end
            n_cmp++; if (pending_cnt !== CNT_W'(mpend)) begin n_fail++; $display("[TB] FAIL rnd_pending@%0d: got %0d expected %0d", c, pending_cnt, mpend); end
            n_cmp++; if (cache_req_valid !== e_valid) begin n_fail++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", c, cache_req_valid, e_valid); end
            n_cmp++; if (cache_req_addr !== e_addr || cache_req_be !== e_be || cache_req_wr !== e_wr)
                begin n_fail++; $display("[TB] FAIL rnd_head@%0d: got addr %0h be %0h wr %b expected addr %0h be %0h wr %b", c, cache_req_addr, cache_req_be, cache_req_wr, e_addr, e_be, e_wr); end
            if (e_valid && !e_wr) begin
                n_cmp++; if (cache_req_data !== mq[0].data) begin n_fail++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", c, cache_req_data, mq[0].data); end
            end
            n_cmp++; if (wb_valid !== cache_rsp_valid || read_data !== cache_rsp_data) begin n_fail++; $display("[TB] FAIL rnd_rsp@%0d: got %b %0h expected %b %0h", c, wb_valid, read_data, cache_rsp_valid, cache_rsp_data); end
            n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_rsp_err@%0d: got %b expected 0", c, rsp_err); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        mpend = 0;
        idle_inputs();
        test_reset();
        test_queue_fill();
        test_byte_store();
        test_pending_cap();
        test_simultaneous();
        test_reset_midflight();
        test_error_flag();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
